// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in serial-out transmitter.
// PISO_PARITY_EN adds one even-parity bit to the end of every frame.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

`ifdef PISO_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   function automatic int nbits(input int width, input bit parity_en);
      return width + (parity_en ? 1 : 0);
   endfunction

   function automatic int count_width(input int n);
      return $clog2(n + 1);
   endfunction

   // Count width for the default 4-bit word; instances size their own count from WIDTH.
   localparam int DEFAULT_COUNT_W = count_width(nbits(4, PARITY_EN));

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with load/ready handshake, frame and done strobes.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
//
// state | meaning
// IDLE  | no frame in flight, ready to capture a word
// SHIFT | one frame bit per cycle on serial_out; last bit cycle also accepts a new word
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] parallel_in,
   output logic             ready,
   output logic             serial_out,
   output logic             frame,
   output logic             done
);

   localparam int NBITS = nbits(WIDTH, PARITY_EN);
   localparam int CNT_W = count_width(NBITS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);

   state_t           state, state_n;
   logic [WIDTH-1:0] sh_q, sh_n, sh_adv;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             last, accept, data_bit, bit_sel;

   assign last   = (state == SHIFT) && (cnt_q == LAST);
   assign frame  = (state == SHIFT);
   assign done   = last;
   assign ready  = (state == IDLE) || last;
   assign accept = load && ready;

   assign data_bit = (MSB_FIRST != 0) ? sh_q[WIDTH-1] : sh_q[0];
   assign sh_adv   = (MSB_FIRST != 0) ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

`ifdef PISO_PARITY_EN
   logic par_q, par_n;

   // The parity bit occupies the cycle right after the last data bit.
   assign bit_sel = (cnt_q == CNT_W'(WIDTH)) ? par_q : data_bit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) par_q <= 1'b0;
      else       par_q <= par_n;
   end

   always_comb begin
      par_n = par_q;
      if (accept) par_n = ^parallel_in;
   end
`else
   assign bit_sel = data_bit;
`endif

   assign serial_out = frame & bit_sel;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         sh_q  <= '0;
         cnt_q <= '0;
      end else begin
         state <= state_n;
         sh_q  <= sh_n;
         cnt_q <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      sh_n    = sh_q;
      cnt_n   = cnt_q;
      if (accept) begin
         state_n = SHIFT;
         sh_n    = parallel_in;
         cnt_n   = '0;
      end else if (state == SHIFT) begin
         if (last) begin
            state_n = IDLE;
            cnt_n   = '0;
         end else begin
            sh_n  = sh_adv;
            cnt_n = cnt_q + 1'b1;
         end
      end
   end

endmodule
